pipe_fetch_stage: RTL and testbench

Fetch stage and F/D pipeline registers of the Y86-64 five-stage pipeline. Holds the predicted PC, selects the fetch PC from the predicted, mispredicted-branch and return paths, and splits the instruction bytes. It also computes fetch status and the next-PC prediction, then loads the decode pipeline register. It sits directly upstream of decode and obeys `F_stall`, `D_stall` and `D_bubble` from the pipeline control logic.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/pipe_instr_split.sv | 40 ++++
 rtl/pipe_fetch_stage.sv | 118 +++++++++++
 tb/tb_pipe_fetch_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register sentinel and status codes.
package y86_pkg;

    localparam int DEF_ADDR_W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

endpackage

// File: rtl/pipe_instr_split.sv
// Combinational instruction splitter: ten fetched bytes into Y86-64 fields.
module pipe_instr_split
    import y86_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [79:0]       imem_data,
    input  logic              imem_error,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        ra,
    output logic [3:0]        rb,
    output logic [ADDR_W-1:0] valc,
    output logic              need_regids,
    output logic              need_valc,
    output logic              instr_valid
);

    logic [63:0] valc_raw;

    always_comb begin
        icode = imem_error ? I_NOP : imem_data[7:4];
        ifun  = imem_error ? 4'h0  : imem_data[3:0];

        need_regids = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                    I_OPQ, I_PUSHQ, I_POPQ};
        need_valc   = icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
        instr_valid = icode <= I_POPQ;

        ra = need_regids ? imem_data[15:12] : RNONE;
        rb = need_regids ? imem_data[11:8]  : RNONE;

        // constant follows the register byte when there is one
        valc_raw = 64'h0;
        if (need_valc)
            valc_raw = need_regids ? imem_data[79:16] : imem_data[71:8];
        valc = ADDR_W'(valc_raw);
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Y86-64 fetch stage: PC select, split, status, next-PC prediction, F and D registers.
module pipe_fetch_stage
    import y86_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [79:0]       imem_data,
    input  logic              imem_error,
    output logic [ADDR_W-1:0] f_predPC,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [ADDR_W-1:0] D_valC,
    output logic [ADDR_W-1:0] D_valP
);

    logic [ADDR_W-1:0] F_predPC;
    logic [ADDR_W-1:0] f_pc;
    logic [ADDR_W-1:0] f_valc;
    logic [ADDR_W-1:0] f_valp;
    logic [3:0]        f_icode, f_ifun, f_ra, f_rb;
    logic [3:0]        f_len;
    logic [2:0]        f_stat;
    logic              need_regids, need_valc, instr_valid;

    pipe_instr_split #(.ADDR_W(ADDR_W)) u_split (
        .imem_data   (imem_data),
        .imem_error  (imem_error),
        .icode       (f_icode),
        .ifun        (f_ifun),
        .ra          (f_ra),
        .rb          (f_rb),
        .valc        (f_valc),
        .need_regids (need_regids),
        .need_valc   (need_valc),
        .instr_valid (instr_valid)
    );

    // mispredicted branch outranks a returning RET
    always_comb begin
        if (M_icode == I_JXX && !M_Cnd)
            f_pc = M_valA;
        else if (W_icode == I_RET)
            f_pc = W_valM;
        else
            f_pc = F_predPC;
    end

    always_comb begin
        f_len  = 4'd1 + {3'b000, need_regids} + {need_valc, 3'b000};
        f_valp = f_pc + ADDR_W'(f_len);

        if (imem_error)
            f_stat = S_ADR;
        else if (!instr_valid)
            f_stat = S_INS;
        else if (f_icode == I_HALT)
            f_stat = S_HLT;
        else
            f_stat = S_AOK;

        f_predPC = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;
    end

    assign imem_addr = f_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            F_predPC <= RESET_PC;
        else if (!F_stall)
            F_predPC <= f_predPC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_stat  <= S_BUB;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
        end else if (D_stall) begin
            D_stat  <= D_stat;
        end else if (D_bubble) begin
            D_stat  <= S_BUB;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
        end else begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= f_valc;
            D_valP  <= f_valp;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Randomized bench for pipe_fetch_stage against a byte-level Y86-64 fetch model.
module tb_pipe_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [63:0] imem_addr, f_predPC;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } dreg_t;

    logic [63:0] m_pred;
    dreg_t       m_d;
    dreg_t       bubble_d;

    pipe_fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
        .f_predPC(f_predPC),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decode the ten bytes at pc the way the ISA describes an instruction.
    function automatic dreg_t decode(input logic [79:0] data, input logic err,
                                     input logic [63:0] pc);
        dreg_t      d;
        logic [7:0] b [10];
        int         has_reg, has_c, len;
        for (int i = 0; i < 10; i++) b[i] = data[8*i +: 8];
        d.icode = err ? 4'd1 : b[0][7:4];
        d.ifun  = err ? 4'd0 : b[0][3:0];
        has_reg = (d.icode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11}) ? 1 : 0;
        has_c   = (d.icode inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8}) ? 1 : 0;
        d.ra    = has_reg ? b[1][7:4] : 4'hF;
        d.rb    = has_reg ? b[1][3:0] : 4'hF;
        d.valc  = 64'h0;
        if (has_c != 0)
            for (int k = 0; k < 8; k++)
                d.valc = d.valc | ({56'h0, b[k + 1 + has_reg]} << (8 * k));
        len    = 1 + has_reg + 8 * has_c;
        d.valp = pc + 64'(len);
        if (err)                d.stat = 3'd3;
        else if (d.icode > 11)  d.stat = 3'd4;
        else if (d.icode == 0)  d.stat = 3'd2;
        else                    d.stat = 3'd1;
        return d;
    endfunction

    function automatic logic [63:0] model_pc();
        if (M_icode == 4'd7 && !M_Cnd) return M_valA;
        if (W_icode == 4'd9)           return W_valM;
        return m_pred;
    endfunction

    task automatic chk_d(input string tag);
        chk({tag, ".stat"},  {61'h0, D_stat},  {61'h0, m_d.stat});
        chk({tag, ".icode"}, {60'h0, D_icode}, {60'h0, m_d.icode});
        chk({tag, ".ifun"},  {60'h0, D_ifun},  {60'h0, m_d.ifun});
        chk({tag, ".rA"},    {60'h0, D_rA},    {60'h0, m_d.ra});
        chk({tag, ".rB"},    {60'h0, D_rB},    {60'h0, m_d.rb});
        chk({tag, ".valC"},  D_valC,           m_d.valc);
        chk({tag, ".valP"},  D_valP,           m_d.valp);
    endtask

    // Inputs are set before calling; checks comb outputs, clocks once, checks D.
    task automatic step(input string tag);
        logic [63:0] pc, pred;
        dreg_t       f;
        #1;
        pc   = model_pc();
        f    = decode(imem_data, imem_error, pc);
        pred = (f.icode == 4'd7 || f.icode == 4'd8) ? f.valc : f.valp;
        chk({tag, ".imem_addr"}, imem_addr, pc);
        chk({tag, ".f_predPC"},  f_predPC,  pred);
        @(posedge clk);
        if (!F_stall) m_pred = pred;
        if (!D_stall) m_d = D_bubble ? bubble_d : f;
        #1;
        chk_d(tag);
    endtask

    task automatic quiet();
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_icode = 4'd1; M_Cnd = 0; M_valA = 64'h0;
        W_icode = 4'd1; W_valM = 64'h0;
        imem_error = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_pred = 64'h0;
        m_d    = bubble_d;
        chk("rst.imem_addr", imem_addr, 64'h0);
        chk_d("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bubble_d = '{stat: 3'd0, icode: 4'd1, ifun: 4'd0, ra: 4'hF, rb: 4'hF,
                     valc: 64'h0, valp: 64'h0};
        rst_n = 1'b1;
        quiet();
        imem_data = 80'h0;
        m_pred = 64'h0;
        m_d    = bubble_d;
        @(negedge clk);
        do_reset();

        // irmovq $10, %rbx at address 0
        imem_data = 80'h0000_0000_0000_000A_F330;
        step("irmovq");
        chk("irmovq.D_icode", {60'h0, D_icode}, 64'd3);
        chk("irmovq.D_rB",    {60'h0, D_rB},    64'd3);
        chk("irmovq.D_valC",  D_valC,           64'd10);
        chk("irmovq.D_valP",  D_valP,           64'd10);
        #1 chk("irmovq.next_pc", imem_addr, 64'd10);

        // jump at 0x20 to 0x40, reached via a mispredict redirect
        M_icode = 4'd7; M_Cnd = 0; M_valA = 64'h20;
        imem_data = 80'h0000_0000_0000_0000_4070;
        #1 chk("jxx.f_predPC", f_predPC, 64'h40);
        step("jxx");
        M_valA = 64'h29;
        #1 chk("redir.imem_addr", imem_addr, 64'h29);
        step("redir");

        // mispredict outranks RET
        M_valA = 64'h50; W_icode = 4'd9; W_valM = 64'h100;
        #1 chk("prio.imem_addr", imem_addr, 64'h50);
        step("prio");
        quiet();

        // load-use stall for two cycles, then stall+bubble, then bubble
        imem_data = 80'h0000_0000_0000_0000_3460;
        step("pre_stall");
        F_stall = 1; D_stall = 1;
        step("stall1");
        imem_data = 80'h1234;
        step("stall2");
        D_bubble = 1;
        step("stall_bub");
        F_stall = 0; D_stall = 0;
        step("bubble");
        chk("bubble.D_icode", {60'h0, D_icode}, 64'd1);
        D_bubble = 0;

        imem_error = 1;
        step("imem_err");
        chk("imem_err.D_stat", {61'h0, D_stat}, 64'd3);
        imem_error = 0;
        imem_data = 80'h00C0;
        step("sins");
        chk("sins.D_stat", {61'h0, D_stat}, 64'd4);
        imem_data = 80'h0000;
        step("shlt");
        chk("shlt.D_stat", {61'h0, D_stat}, 64'd2);

        // reset asserted during a stall
        F_stall = 1; D_stall = 1;
        imem_data = 80'h0000_0000_0000_000A_F330;
        @(negedge clk);
        #2;
        quiet();
        F_stall = 1; D_stall = 1;
        do_reset();
        quiet();
        step("post_rst");

        for (int n = 0; n < 600; n++) begin
            F_stall    = ($urandom_range(0, 5) == 0);
            D_stall    = F_stall ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            D_bubble   = ($urandom_range(0, 7) == 0);
            M_icode    = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            M_Cnd      = 1'($urandom);
            M_valA     = {$urandom, $urandom};
            W_icode    = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            W_valM     = {$urandom, $urandom};
            imem_error = ($urandom_range(0, 15) == 0);
            imem_data  = 80'({$urandom, $urandom, $urandom});
            imem_data[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(0, 11));
            step("rand");
            if (n == 300) begin
                @(negedge clk);
                quiet();
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
